msrv32_dmem_access_ctrl: RTL and testbench

MSRV32_DMEM_ACCESS_CTRL -- requirements
Module: msrv32_dmem_access_ctrl

---
 rtl/msrv32_pkg.sv | 31 +++
 rtl/msrv32_store_align.sv | 32 +++
 rtl/msrv32_dmem_access_ctrl.sv | 115 +++++++++++
 tb/tb_msrv32_dmem_access_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared encodings and helpers for the data-memory access path
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } dmem_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/msrv32_store_align.sv
// rtl/msrv32_store_align.sv - byte-lane mask and replicated store data
module msrv32_store_align
    import msrv32_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic [31:0] data
);

    // Replicate the right-aligned store data across lanes; the mask selects the live ones.
    always_comb begin
        mask = 4'b1111;
        data = wdata;
        case (size)
            SZ_BYTE: begin
                mask = 4'b0001 << addr_lo;
                data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                data = {2{wdata[15:0]}};
            end
            default: begin
                mask = 4'b1111;
                data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_access_ctrl.sv
// rtl/msrv32_dmem_access_ctrl.sv - load/store request to AHB-style data bus sequencer
module msrv32_dmem_access_ctrl
    import msrv32_pkg::*;
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic [31:0] req_addr_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic [31:0] req_wdata_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [1:0]  ms_riscv32_mp_data_htrans_out,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    input  logic        ms_riscv32_mp_data_hready_in,
    input  logic        ms_riscv32_mp_data_hresp_in,
    output logic [1:0]  load_size_out,
    output logic        load_unsigned_out,
    output logic [1:0]  iadder_out_1_to_0_out,
    output logic        ahb_resp_out,
    output logic        rsp_valid_out,
    output logic        rsp_error_out,
    output logic        misaligned_out
);

    dmem_state_t state;
    logic [3:0]  align_mask;
    logic [31:0] align_data;
    logic        req_misaligned;

    msrv32_store_align u_store_align (
        .addr_lo (req_addr_in[1:0]),
        .size    (req_size_in),
        .wdata   (req_wdata_in),
        .mask    (align_mask),
        .data    (align_data)
    );

    assign req_misaligned = is_misaligned(req_size_in, req_addr_in[1:0]);
    assign req_ready_out  = (state == ST_IDLE);

    // Transfer sequencer: every bus and response output is a register owned by this block.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state                         <= ST_IDLE;
            ms_riscv32_mp_dmaddr_out      <= 32'h0;
            ms_riscv32_mp_data_htrans_out <= HTRANS_IDLE;
            ms_riscv32_mp_dmwr_req_out    <= 1'b0;
            ms_riscv32_mp_dmwr_mask_out   <= 4'b0000;
            ms_riscv32_mp_dmdata_out      <= 32'h0;
            load_size_out                 <= SZ_BYTE;
            load_unsigned_out             <= 1'b0;
            iadder_out_1_to_0_out         <= 2'b00;
            ahb_resp_out                  <= 1'b0;
            rsp_valid_out                 <= 1'b0;
            rsp_error_out                 <= 1'b0;
            misaligned_out                <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_in) begin
                        load_size_out         <= norm_size(req_size_in);
                        load_unsigned_out     <= req_unsigned_in;
                        iadder_out_1_to_0_out <= req_addr_in[1:0];
                        ahb_resp_out          <= 1'b0;
                        if (req_misaligned) begin
                            // Rejected locally: no bus cycle, answer on the next cycle.
                            state                       <= ST_RESP;
                            ms_riscv32_mp_dmwr_mask_out <= 4'b0000;
                            ms_riscv32_mp_dmdata_out    <= 32'h0;
                            rsp_valid_out               <= 1'b1;
                            rsp_error_out               <= 1'b0;
                            misaligned_out              <= 1'b1;
                        end else begin
                            state                         <= ST_ADDR;
                            ms_riscv32_mp_dmaddr_out      <= req_addr_in;
                            ms_riscv32_mp_data_htrans_out <= HTRANS_NONSEQ;
                            ms_riscv32_mp_dmwr_req_out    <= req_write_in;
                            ms_riscv32_mp_dmwr_mask_out   <= req_write_in ? align_mask : 4'b0000;
                            ms_riscv32_mp_dmdata_out      <= req_write_in ? align_data : 32'h0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (ms_riscv32_mp_data_hready_in) begin
                        state                         <= ST_DATA;
                        ms_riscv32_mp_data_htrans_out <= HTRANS_IDLE;
                        ms_riscv32_mp_dmwr_req_out    <= 1'b0;
                    end
                end
                ST_DATA: begin
                    // hresp only means something on the sample where hready is high.
                    if (ms_riscv32_mp_data_hready_in) begin
                        state         <= ST_RESP;
                        rsp_valid_out <= 1'b1;
                        rsp_error_out <= ms_riscv32_mp_data_hresp_in;
                        ahb_resp_out  <= ms_riscv32_mp_data_hresp_in;
                    end
                end
                ST_RESP: begin
                    state          <= ST_IDLE;
                    rsp_valid_out  <= 1'b0;
                    rsp_error_out  <= 1'b0;
                    misaligned_out <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_dmem_access_ctrl.sv
// tb/tb_msrv32_dmem_access_ctrl.sv - self-checking bench for msrv32_dmem_access_ctrl
module tb_msrv32_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] dmaddr;
    logic [1:0]  htrans;
    logic        dmwr_req;
    logic [3:0]  dmwr_mask;
    logic [31:0] dmdata;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [1:0]  load_size;
    logic        load_uns;
    logic [1:0]  iadder_lo;
    logic        ahb_resp;
    logic        rsp_valid;
    logic        rsp_error;
    logic        misaligned;

    always #5 clk = ~clk;

    msrv32_dmem_access_ctrl dut (
        .ms_riscv32_mp_clk_in          (clk),
        .ms_riscv32_mp_rst_in          (rst),
        .req_valid_in                  (req_valid),
        .req_ready_out                 (req_ready),
        .req_write_in                  (req_write),
        .req_addr_in                   (req_addr),
        .req_size_in                   (req_size),
        .req_unsigned_in               (req_uns),
        .req_wdata_in                  (req_wdata),
        .ms_riscv32_mp_dmaddr_out      (dmaddr),
        .ms_riscv32_mp_data_htrans_out (htrans),
        .ms_riscv32_mp_dmwr_req_out    (dmwr_req),
        .ms_riscv32_mp_dmwr_mask_out   (dmwr_mask),
        .ms_riscv32_mp_dmdata_out      (dmdata),
        .ms_riscv32_mp_data_hready_in  (hready),
        .ms_riscv32_mp_data_hresp_in   (hresp),
        .load_size_out                 (load_size),
        .load_unsigned_out             (load_uns),
        .iadder_out_1_to_0_out         (iadder_lo),
        .ahb_resp_out                  (ahb_resp),
        .rsp_valid_out                 (rsp_valid),
        .rsp_error_out                 (rsp_error),
        .misaligned_out                (misaligned)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_cyc = -1;
    logic check_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        exp_ready = 1'b1;
    logic [1:0]  exp_htrans = 2'b00;
    logic        exp_dmwr = 1'b0;
    logic [3:0]  exp_mask = 4'h0;
    logic [31:0] exp_dmdata = 32'h0;
    logic [31:0] exp_dmaddr = 32'h0;
    logic        exp_rsp_valid = 1'b0;
    logic        exp_rsp_error = 1'b0;
    logic        exp_mis = 1'b0;
    logic [1:0]  exp_load_size = 2'b00;
    logic        exp_uns = 1'b0;
    logic [1:0]  exp_iadder = 2'b00;
    logic        exp_ahb = 1'b0;

    // Observations captured for the literal checks.
    logic        saw_nonseq;
    logic [3:0]  cap_mask;
    logic [31:0] cap_data;
    logic        cap_err;
    logic        cap_mis;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [3:0] model_mask(input logic [31:0] addr, input logic [1:0] sz);
        int n;
        n = nbytes(sz);
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] d;
        int n;
        n = nbytes(sz);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % n) +: 8];
        return d;
    endfunction

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("htrans", 32'(htrans), 32'(exp_htrans));
            chk("dmwr_req", 32'(dmwr_req), 32'(exp_dmwr));
            chk("dmwr_mask", 32'(dmwr_mask), 32'(exp_mask));
            chk("dmdata", dmdata, exp_dmdata);
            if (exp_htrans == 2'b10) chk("dmaddr", dmaddr, exp_dmaddr);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            if (exp_rsp_valid) begin
                chk("rsp_error", 32'(rsp_error), 32'(exp_rsp_error));
                chk("misaligned", 32'(misaligned), 32'(exp_mis));
            end
            chk("load_size", 32'(load_size), 32'(exp_load_size));
            chk("load_unsigned", 32'(load_uns), 32'(exp_uns));
            chk("iadder_lo", 32'(iadder_lo), 32'(exp_iadder));
            chk("ahb_resp", 32'(ahb_resp), 32'(exp_ahb));
        end
        if (htrans == 2'b10) begin
            saw_nonseq = 1'b1;
            cap_mask   = dmwr_mask;
            cap_data   = dmdata;
        end
        if (rsp_valid === 1'b1 && rsp_cyc < 0) begin
            rsp_cyc = cyc;
            cap_err = rsp_error;
            cap_mis = misaligned;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd, input int aw, input int dw,
                          input logic hr);
        logic mis;
        mis        = (addr % nbytes(sz)) != 0;
        saw_nonseq = 1'b0;
        rsp_cyc    = -1;
        cap_err    = 1'b0;
        cap_mis    = 1'b0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = sz;
        req_uns    = uns;
        req_wdata  = wd;
        hready     = 1'b1;
        hresp      = 1'b0;
        acc_cyc    = cyc;
        tick();
        req_valid     = 1'b0;
        req_wdata     = 32'hDEAD_BEEF;
        req_addr      = 32'hFFFF_FFFF;
        exp_load_size = (sz == 2'b11) ? 2'b10 : sz;
        exp_uns       = uns;
        exp_iadder    = addr[1:0];
        exp_ahb       = 1'b0;
        exp_ready     = 1'b0;
        if (mis) begin
            exp_mask      = 4'h0;
            exp_dmdata    = 32'h0;
            exp_htrans    = 2'b00;
            exp_dmwr      = 1'b0;
            exp_rsp_valid = 1'b1;
            exp_rsp_error = 1'b0;
            exp_mis       = 1'b1;
            tick();
        end else begin
            exp_mask      = wr ? model_mask(addr, sz) : 4'h0;
            exp_dmdata    = wr ? model_data(wd, sz) : 32'h0;
            exp_dmaddr    = addr;
            exp_htrans    = 2'b10;
            exp_dmwr      = wr;
            exp_rsp_valid = 1'b0;
            for (int i = 0; i < aw; i++) begin
                hready = 1'b0;
                tick();
            end
            hready = 1'b1;
            tick();
            exp_htrans = 2'b00;
            exp_dmwr   = 1'b0;
            for (int i = 0; i < dw; i++) begin
                hready = 1'b0;
                hresp  = 1'b1;
                tick();
            end
            hready = 1'b1;
            hresp  = hr;
            tick();
            exp_rsp_valid = 1'b1;
            exp_rsp_error = hr;
            exp_mis       = 1'b0;
            exp_ahb       = hr;
            hresp = 1'b0;
            tick();
        end
        exp_rsp_valid = 1'b0;
        exp_ready     = 1'b1;
    endtask

    initial begin
        // Reset state while reset is held.
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_mask", 32'(dmwr_mask), 32'd0);
        chk("rst_dmaddr", dmaddr, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_en = 1'b1;
        tick();

        // Store byte 0xA5 to 0x1003, zero wait states.
        do_txn(1'b1, 32'h0000_1003, 2'b00, 1'b0, 32'h0000_00A5, 0, 0, 1'b0);
        chk("sb_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
        chk("sb_mask", 32'(cap_mask), 32'h8);
        chk("sb_data", cap_data, 32'hA5A5_A5A5);
        chk("sb_err", 32'(cap_err), 32'd0);
        tick();

        // Load half unsigned from 0x2002, two data wait states.
        do_txn(1'b0, 32'h0000_2002, 2'b01, 1'b1, 32'h0, 0, 2, 1'b0);
        chk("lhu_latency", 32'(rsp_cyc - acc_cyc), 32'd5);
        chk("lhu_size", 32'(load_size), 32'd1);
        chk("lhu_iadder", 32'(iadder_lo), 32'd2);
        chk("lhu_uns", 32'(load_uns), 32'd1);

        // Misaligned word load from 0x3001.
        do_txn(1'b0, 32'h0000_3001, 2'b10, 1'b0, 32'h0, 0, 0, 1'b0);
        chk("mis_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
        chk("mis_flag", 32'(cap_mis), 32'd1);
        chk("mis_no_bus", 32'(saw_nonseq), 32'd0);
        chk("mis_ready", 32'(req_ready), 32'd1);

        // Errored word load, then the next accept clears ahb_resp.
        do_txn(1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'h0, 1, 1, 1'b1);
        chk("err_rsp_error", 32'(cap_err), 32'd1);
        chk("err_ahb_hold", 32'(ahb_resp), 32'd1);
        do_txn(1'b1, 32'h0000_5002, 2'b01, 1'b0, 32'h1234_BEEF, 1, 0, 1'b0);
        chk("sh_mask", 32'(cap_mask), 32'hC);
        chk("sh_data", cap_data, 32'hBEEF_BEEF);
        chk("err_ahb_cleared", 32'(ahb_resp), 32'd0);

        // Further patterns: size 11 store, signed byte load, misaligned half store, lane 0 byte.
        do_txn(1'b1, 32'h0000_6004, 2'b11, 1'b0, 32'h89AB_CDEF, 0, 1, 1'b0);
        chk("sw11_mask", 32'(cap_mask), 32'hF);
        chk("sw11_size", 32'(load_size), 32'd2);
        do_txn(1'b0, 32'h0000_7001, 2'b00, 1'b0, 32'h0, 2, 0, 1'b0);
        do_txn(1'b1, 32'h0000_7003, 2'b01, 1'b0, 32'h0000_5555, 0, 0, 1'b0);
        do_txn(1'b1, 32'h0000_8000, 2'b00, 1'b0, 32'h0000_003C, 0, 0, 1'b1);
        do_txn(1'b1, 32'h0000_8001, 2'b00, 1'b0, 32'h0000_0011, 0, 0, 1'b0);
        tick();

        // Reset asserted mid-ADDR with hready low.
        rsp_cyc   = -1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_9000;
        req_size  = 2'b10;
        req_uns   = 1'b1;
        req_wdata = 32'h0BAD_F00D;
        hready    = 1'b0;
        tick();
        req_valid     = 1'b0;
        exp_ready     = 1'b0;
        exp_htrans    = 2'b10;
        exp_dmwr      = 1'b1;
        exp_dmaddr    = 32'h0000_9000;
        exp_mask      = 4'hF;
        exp_dmdata    = 32'h0BAD_F00D;
        exp_load_size = 2'b10;
        exp_uns       = 1'b1;
        exp_iadder    = 2'b00;
        tick();
        check_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_htrans", 32'(htrans), 32'd0);
        chk("mid_rst_dmwr", 32'(dmwr_req), 32'd0);
        chk("mid_rst_mask", 32'(dmwr_mask), 32'd0);
        chk("mid_rst_dmaddr", dmaddr, 32'd0);
        chk("mid_rst_dmdata", dmdata, 32'd0);
        chk("mid_rst_rsp", 32'({rsp_valid, rsp_error, misaligned, ahb_resp}), 32'd0);
        chk("mid_rst_load", 32'({load_size, load_uns, iadder_lo}), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        hready        = 1'b1;
        exp_ready     = 1'b1;
        exp_htrans    = 2'b00;
        exp_dmwr      = 1'b0;
        exp_mask      = 4'h0;
        exp_dmdata    = 32'h0;
        exp_load_size = 2'b00;
        exp_uns       = 1'b0;
        exp_iadder    = 2'b00;
        exp_ahb       = 1'b0;
        exp_rsp_valid = 1'b0;
        tick();
        check_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_no_rsp", 32'(rsp_cyc), 32'hFFFF_FFFF);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Traffic resumes normally after reset.
        do_txn(1'b1, 32'h0000_A002, 2'b00, 1'b0, 32'h0000_0077, 0, 0, 1'b0);
        chk("resume_mask", 32'(cap_mask), 32'h4);
        chk("resume_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
        tick();
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
